// File: rtl/lenet_pkg.sv
// ============================================================================
// Module : lenet_pkg
// Brief  : Shared LeNet feature-map constants and the pooling sequencer states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lenet_pkg;

  localparam int unsigned N_DEFAULT = 16;

  // Plane sizes feeding the two pooling layers (C1 -> S2, C3 -> S4)
  localparam int unsigned C1_W = 28;
  localparam int unsigned C1_H = 28;
  localparam int unsigned C3_W = 10;
  localparam int unsigned C3_H = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVEN  = 2'd1,
    ODD   = 2'd2,
    DRAIN = 2'd3
  } pool_state_e;

endpackage

`default_nettype wire

// File: rtl/maxpool2x2_stream_ctrl_if.sv
// ============================================================================
// Module : maxpool2x2_stream_ctrl_if
// Brief  : Frame control plus pixel-in / pooled-out valid-ready streams.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface maxpool2x2_stream_ctrl_if
  import lenet_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) ();

  logic         start;
  logic         busy;
  logic         done;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_last;

  // Master is the frame source / result sink; slave is the sequencer.
  modport master (
    output start, in_valid, in_data, out_ready,
    input  busy, done, in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output busy, done, in_ready, out_valid, out_data, out_last
  );

endinterface

`default_nettype wire

// File: rtl/maxpool2x2_stream_ctrl_maxpool2x2.sv
// ============================================================================
// Module : maxpool2x2
// Brief  : Combinational unsigned max of a 2x2 block packed top-left first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module maxpool2x2
  import lenet_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic [4*N-1:0] blk_in,
  output logic [N-1:0]   max_out
);

  logic [N-1:0] w_top_max;
  logic [N-1:0] w_bot_max;

  always_comb begin
    w_top_max = (blk_in[4*N-1 -: N] >= blk_in[3*N-1 -: N]) ? blk_in[4*N-1 -: N] : blk_in[3*N-1 -: N];
    w_bot_max = (blk_in[2*N-1 -: N] >= blk_in[N-1 -: N])   ? blk_in[2*N-1 -: N] : blk_in[N-1 -: N];
    max_out   = (w_top_max >= w_bot_max) ? w_top_max : w_bot_max;
  end

endmodule

`default_nettype wire

// File: rtl/maxpool2x2_stream_ctrl.sv
// ============================================================================
// Module : maxpool2x2_stream_ctrl
// Brief  : Streams a plane row-major, buffers even rows, pools 2x2 blocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module maxpool2x2_stream_ctrl
  import lenet_pkg::*;
#(
  parameter int unsigned N     = N_DEFAULT,
  parameter int unsigned IMG_W = C1_W,
  parameter int unsigned IMG_H = C1_H
) (
  input  logic                      clk,
  input  logic                      rst_n,
  maxpool2x2_stream_ctrl_if.slave   pool_if
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
    $error("maxpool2x2_stream_ctrl: IMG_W must be even and >= 2");
  end
  if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
    $error("maxpool2x2_stream_ctrl: IMG_H must be even and >= 2");
  end

  pool_state_e   r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [N-1:0]  r_left;
  logic [N-1:0]  r_out_data;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  linebuf [IMG_W];

  logic          w_in_ready;
  logic          w_in_fire;
  logic          w_new_res;
  logic          w_col_end;
  logic          w_row_end;
  logic [CW-1:0] w_col_pair;
  logic [4*N-1:0] w_block;
  logic [N-1:0]  w_pool_max;

  // One-entry output register: a pixel may enter whenever the slot is free or draining.
  assign w_in_ready = ((r_state == EVEN) || (r_state == ODD)) && (!r_out_valid || pool_if.out_ready);
  assign w_in_fire  = pool_if.in_valid && w_in_ready;
  assign w_col_end  = (r_col == CW'(IMG_W - 1));
  assign w_row_end  = (r_row == RW'(IMG_H - 1));
  assign w_new_res  = w_in_fire && (r_state == ODD) && r_col[0];
  assign w_col_pair = r_col - CW'(1);
  assign w_block    = {linebuf[w_col_pair], linebuf[r_col], r_left, pool_if.in_data};

  maxpool2x2 #(.N(N)) u_maxpool2x2 (
    .blk_in  (w_block),
    .max_out (w_pool_max)
  );

  always_ff @(posedge clk) begin
    if (w_in_fire && (r_state == EVEN)) begin
      linebuf[r_col] <= pool_if.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_left      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_new_res) begin
        r_out_data  <= w_pool_max;
        r_out_valid <= 1'b1;
        r_out_last  <= w_row_end && w_col_end;
      end else if (pool_if.out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (pool_if.start) begin
            r_state <= EVEN;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b1;
          end
        end
        EVEN: begin
          if (w_in_fire) begin
            if (w_col_end) begin
              r_col   <= '0;
              r_row   <= r_row + RW'(1);
              r_state <= ODD;
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        ODD: begin
          if (w_in_fire) begin
            if (!r_col[0]) begin
              r_left <= pool_if.in_data;
            end
            if (w_col_end) begin
              r_col <= '0;
              if (w_row_end) begin
                r_row   <= '0;
                r_state <= DRAIN;
              end else begin
                r_row   <= r_row + RW'(1);
                r_state <= EVEN;
              end
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        DRAIN: begin
          // The final result was loaded on the way in, so its accept ends the frame.
          if (r_out_valid && pool_if.out_ready) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pool_if.in_ready  = w_in_ready;
  assign pool_if.out_valid = r_out_valid;
  assign pool_if.out_data  = r_out_data;
  assign pool_if.out_last  = r_out_last;
  assign pool_if.busy      = r_busy;
  assign pool_if.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_maxpool2x2_stream_ctrl.sv
// ============================================================================
// Module : tb_maxpool2x2_stream_ctrl
// Brief  : Directed 4x4 frames plus a randomised 28x28 frame against a model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_maxpool2x2_stream_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  maxpool2x2_stream_ctrl_if #(.N(16)) ifa ();
  maxpool2x2_stream_ctrl_if #(.N(16)) ifb ();

  maxpool2x2_stream_ctrl #(.N(16), .IMG_W(4), .IMG_H(4)) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .pool_if (ifa.slave)
  );

  maxpool2x2_stream_ctrl #(.N(16), .IMG_W(28), .IMG_H(28)) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .pool_if (ifb.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] pix_a [16];
  logic [15:0] got_q [$];
  logic        got_last_q [$];

  logic [15:0] pix_b [784];
  logic [15:0] exp_b [196];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_seq_a();
    for (int i = 0; i < 16; i++) pix_a[i] = 16'(i + 1);
  endtask

  // rdy_mode 0: always ready; 2: stall the first result for 20 cycles.
  task automatic run_a(input int rdy_mode, input int gap_pct, input bit start_mid, input int stop_pi);
    int pi       = 0;
    int cyc      = 0;
    int dones    = 0;
    int last_acc = -10;
    int done_cyc = -1;
    int hold     = 0;
    got_q.delete();
    got_last_q.delete();
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    while (cyc < 400) begin
      ifa.in_valid = (pi < 16) && (int'($urandom_range(99)) >= gap_pct);
      ifa.in_data  = pix_a[pi % 16];
      ifa.start    = start_mid && (cyc == 8);
      ifa.out_ready = 1'b1;
      if (rdy_mode == 2 && ifa.out_valid && got_q.size() == 0 && hold < 20) begin
        ifa.out_ready = 1'b0;
        hold++;
      end
      #1;
      if (cyc == 0) check("busy_after_start", 32'(ifa.busy), 32'd1);
      if (rdy_mode == 2 && hold == 20 && got_q.size() == 0 && !ifa.out_ready) begin
        check("stall_data", 32'(ifa.out_data), 32'd6);
        check("stall_valid", 32'(ifa.out_valid), 32'd1);
        check("stall_in_ready", 32'(ifa.in_ready), 32'd0);
        check("stall_pix_count", 32'(pi), 32'd6);
      end
      if (ifa.done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          check("busy_at_done", 32'(ifa.busy), 32'd0);
        end
      end
      if (ifa.in_valid && ifa.in_ready) pi++;
      if (ifa.out_valid && ifa.out_ready) begin
        got_q.push_back(ifa.out_data);
        got_last_q.push_back(ifa.out_last);
        last_acc = cyc;
      end
      if (pi >= stop_pi) break;
      if (done_cyc >= 0 && cyc > done_cyc + 3) break;
      cyc++;
      @(negedge clk);
    end
    if (stop_pi >= 99) begin
      ifa.in_valid = 1'b0;
      ifa.start    = 1'b0;
      check("n_out", 32'(got_q.size()), 32'd4);
      check("done_count", 32'(dones), 32'd1);
      check("done_latency", 32'(done_cyc), 32'(last_acc + 1));
      check("idle_in_ready", 32'(ifa.in_ready), 32'd0);
      check("idle_busy", 32'(ifa.busy), 32'd0);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_data%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hdead_beef, 32'(ex[i]));
      check($sformatf("%s_last%0d", tag, i), (i < got_last_q.size()) ? 32'(got_last_q[i]) : 32'hdead_beef,
            (i == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int k, dones, nlast, last_idx, cyc;
    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
    ifb.start = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_out_data", 32'(ifa.out_data), 32'd0);
    check("rst_out_last", 32'(ifa.out_last), 32'd0);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_done", 32'(ifa.done), 32'd0);
    check("rst_in_ready", 32'(ifa.in_ready), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready_pre", 32'(ifa.in_ready), 32'd0);

    // Basic frame 1..16
    load_seq_a();
    run_a(0, 0, 1'b0, 99);
    check_outs("seq", 16'd6, 16'd8, 16'd14, 16'd16);

    // Backpressure on the first result
    run_a(2, 0, 1'b0, 99);
    check_outs("bp", 16'd6, 16'd8, 16'd14, 16'd16);

    // Unsigned compare: a signed compare would pick 0x7FFF
    for (int i = 0; i < 16; i++) pix_a[i] = 16'h0;
    pix_a[0] = 16'h0001; pix_a[1] = 16'hFFFF; pix_a[4] = 16'h8000; pix_a[5] = 16'h7FFF;
    pix_a[14] = 16'h0003;
    run_a(0, 0, 1'b0, 99);
    check_outs("unsigned", 16'hFFFF, 16'h0000, 16'h0000, 16'h0003);

    // Reset in the middle of the odd row while a result is pending
    load_seq_a();
    run_a(0, 0, 1'b0, 6);
    @(posedge clk);
    #2;
    ifa.in_valid = 1'b0;
    check("pre_reset_valid", 32'(ifa.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ifa.out_valid), 32'd0);
    check("async_rst_data", 32'(ifa.out_data), 32'd0);
    check("async_rst_busy", 32'(ifa.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_a(0, 0, 1'b0, 99);
    check_outs("post_rst", 16'd6, 16'd8, 16'd14, 16'd16);

    // start while busy plus input gaps
    run_a(0, 30, 1'b1, 99);
    check_outs("start_busy", 16'd6, 16'd8, 16'd14, 16'd16);

    // 28x28 random frame with random gaps and backpressure
    for (int i = 0; i < 784; i++) pix_b[i] = 16'($urandom);
    for (int r = 0; r < 14; r++) begin
      for (int c = 0; c < 14; c++) begin
        logic [15:0] m;
        m = pix_b[(2*r)*28 + 2*c];
        if (pix_b[(2*r)*28 + 2*c + 1] > m) m = pix_b[(2*r)*28 + 2*c + 1];
        if (pix_b[(2*r+1)*28 + 2*c] > m) m = pix_b[(2*r+1)*28 + 2*c];
        if (pix_b[(2*r+1)*28 + 2*c + 1] > m) m = pix_b[(2*r+1)*28 + 2*c + 1];
        exp_b[r*14 + c] = m;
      end
    end
    k = 0; dones = 0; nlast = 0; last_idx = -1; cyc = 0;
    begin
      int pb;
      pb = 0;
      @(negedge clk);
      ifb.start = 1'b1;
      @(negedge clk);
      ifb.start = 1'b0;
      while (cyc < 20000) begin
        ifb.in_valid  = (pb < 784) && ($urandom_range(99) < 70);
        ifb.in_data   = pix_b[pb % 784];
        ifb.out_ready = ($urandom_range(99) < 60);
        #1;
        if (ifb.done) dones++;
        if (ifb.in_valid && ifb.in_ready) pb++;
        if (ifb.out_valid && ifb.out_ready) begin
          if (k < 196) check($sformatf("rand_out%0d", k), 32'(ifb.out_data), 32'(exp_b[k]));
          if (ifb.out_last) begin nlast++; last_idx = k; end
          k++;
        end
        if (dones > 0 && pb >= 784) begin
          repeat (3) begin
            @(negedge clk);
            #1;
            if (ifb.done) dones++;
          end
          break;
        end
        cyc++;
        @(negedge clk);
      end
      ifb.in_valid = 1'b0;
    end
    check("rand_n_out", 32'(k), 32'd196);
    check("rand_done_count", 32'(dones), 32'd1);
    check("rand_last_count", 32'(nlast), 32'd1);
    check("rand_last_idx", 32'(last_idx), 32'd195);
    check("rand_idle_busy", 32'(ifb.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
